// File: rtl/bit_ror_unit_pkg.sv
// Shared ALU constants and word/shift-amount types used by the rotate unit.
package bit_ror_unit_pkg;
  localparam int WORD_W  = 32;
  localparam int SHAMT_W = 5;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [SHAMT_W-1:0] shamt_t;
endpackage

// File: rtl/bit_ror_unit_if.sv
// Operand/result bundle between the ALU front end and the rotate unit.
// Handshake: a transfer happens on every rising edge where in_valid is high;
// there is no ready, so the producer never stalls. out_valid marks rx as new.
interface bit_ror_unit_if
  import bit_ror_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             in_valid;
  logic [WIDTH-1:0] rin;
  logic [SHW-1:0]   n;
  logic             out_valid;
  logic [WIDTH-1:0] rx;

  modport master (
    output in_valid, rin, n,
    input  out_valid, rx
  );

  modport slave (
    input  in_valid, rin, n,
    output out_valid, rx
  );
endinterface

// File: rtl/bit_ror_unit_ror_barrel_comb.sv
// Purely combinational log2 barrel rotator: stage k rotates right by 2^k
// when n[k] is set, otherwise passes its input through.
module ror_barrel_comb
  import bit_ror_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] rin,
  input  logic [SHW-1:0]   n,
  output logic [WIDTH-1:0] rotated
);
  logic [WIDTH-1:0] acc;

  always_comb begin
    acc = rin;
    for (int k = 0; k < SHW; k++) begin
      if (n[k]) begin
        acc = (acc >> (1 << k)) | (acc << (WIDTH - (1 << k)));
      end
    end
    rotated = acc;
  end
endmodule

// File: rtl/bit_ror_unit.sv
// Registered 32-bit rotate-right unit: barrel rotator followed by a result
// register and a valid flop, giving one cycle of latency at full throughput.
module bit_ror_unit
  import bit_ror_unit_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         reset,
  bit_ror_unit_if.slave bus
);
  logic [WIDTH-1:0] rotated;

  ror_barrel_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_barrel (
    .rin     (bus.rin),
    .n       (bus.n),
    .rotated (rotated)
  );

  // rx only loads on accepted inputs, so idle-cycle garbage on rin/n never reaches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rx        <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.rx <= rotated;
      end
    end
  end
endmodule

// File: tb/tb_bit_ror_unit.sv
// Directed and randomised checks of bit_ror_unit against a reference rotate.
module tb_bit_ror_unit;
  import bit_ror_unit_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  word_t exp_q[$];

  bit_ror_unit_if bus ();

  bit_ror_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: take the low word of the doubled operand shifted right by n.
  function automatic word_t ref_ror(input word_t v, input shamt_t sh);
    logic [2*WORD_W-1:0] d;
    d = {v, v} >> sh;
    return d[WORD_W-1:0];
  endfunction

  task automatic check_word(input string tag, input word_t obs, input word_t exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: rx observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: out_valid observed %b expected %b", tag, obs, exp);
    end
  endtask

  // driver: present one input for one clock, return #1 after the capturing edge
  task automatic drive(input logic v, input word_t r, input shamt_t sh);
    @(negedge clk);
    bus.in_valid = v;
    bus.rin      = r;
    bus.n        = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input word_t r, input shamt_t sh, input word_t exp);
    drive(1'b1, r, sh);
    check_word(tag, bus.rx, exp);
    check_bit(tag, bus.out_valid, 1'b1);
  endtask

  initial begin
    word_t  last_rx;
    word_t  r;
    shamt_t sh;
    logic   v;

    n_vec = 0;
    n_err = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    bus.rin      = 32'hFFFF_FFFF;
    bus.n        = 5'd3;

    // Reset with a valid input presented: it must be dropped.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'hFFFF_FFFF, 5'd3);
      check_word("reset_rx", bus.rx, 32'h0000_0000);
      check_bit("reset_valid", bus.out_valid, 1'b0);
    end
    @(negedge clk);
    reset = 1'b0;

    step_check("post_reset", 32'h0000_00F0, 5'd4, 32'h0000_000F);
    step_check("mixed", 32'hE0FF_C003, 5'd12, 32'h003E_0FFC);
    step_check("low_wrap5", 32'h000E_1AE1, 5'd5, 32'h0800_70D7);
    step_check("low_wrap1", 32'h0000_0003, 5'd1, 32'h8000_0001);
    step_check("msb_wrap", 32'h8000_0000, 5'd25, 32'h0000_0040);
    step_check("identity", 32'h0000_000F, 5'd0, 32'h0000_000F);
    step_check("max_shift", 32'h0000_0001, 5'd31, 32'h0000_0002);

    // Idle gap before streaming.
    drive(1'b0, 32'hDEAD_BEEF, 5'd7);
    check_bit("gap_valid", bus.out_valid, 1'b0);
    check_word("gap_hold", bus.rx, 32'h0000_0002);

    // Four back-to-back vectors, one per clock.
    step_check("stream0", 32'h000E_1AE1, 5'd5, 32'h0800_70D7);
    step_check("stream1", 32'h0000_0003, 5'd1, 32'h8000_0001);
    step_check("stream2", 32'h8000_0000, 5'd25, 32'h0000_0040);
    step_check("stream3", 32'h0000_000F, 5'd0, 32'h0000_000F);

    // Drop in_valid with junk on the operands: rx holds.
    drive(1'b0, 32'h1234_5678, 5'd9);
    check_bit("hold_valid", bus.out_valid, 1'b0);
    check_word("hold_rx", bus.rx, 32'h0000_000F);
    drive(1'b0, 32'hFFFF_FFFF, 5'd31);
    check_word("hold_rx2", bus.rx, 32'h0000_000F);

    // Reset mid-stream then resume.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 32'hAAAA_5555, 5'd1);
    check_word("midrst_rx", bus.rx, 32'h0000_0000);
    check_bit("midrst_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step_check("after_midrst", 32'hAAAA_5555, 5'd1, 32'hD555_2AAA);

    // Walking one across every rotate amount.
    for (int b = 0; b < WORD_W; b++) begin
      for (int s = 0; s < WORD_W; s++) begin
        r  = word_t'(1) << b;
        sh = shamt_t'(s);
        drive(1'b1, r, sh);
        check_word("walk", bus.rx, word_t'(1) << ((b - s + WORD_W) % WORD_W));
      end
    end

    // Random pairs with random idle gaps, scoreboarded through exp_q.
    last_rx = bus.rx;
    for (int i = 0; i < 10000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = $urandom;
      sh = shamt_t'($urandom_range(0, WORD_W - 1));
      exp_q.push_back(v ? ref_ror(r, sh) : last_rx);
      drive(v, r, sh);
      last_rx = exp_q.pop_front();
      check_word("random_rx", bus.rx, last_rx);
      check_bit("random_valid", bus.out_valid, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bit_ror_unit.md
Name: bit_ror_unit

Overview:
- Registered 32-bit rotate-right unit for the ALU datapath.
- Rotates operand `rin` right by `n` bit positions (0..31). Bits shifted out of bit 0 re-enter at bit 31.
- Result is captured in an output register, so latency is one clock.
- Sits beside the other ALU shift/logic units; the ALU result mux selects `rx` when `out_valid` is high.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two.
- SHW, $clog2(WIDTH) = 5, width of the rotate-amount port.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/amount qualifier; a result is captured only when high.
- rin  input  WIDTH  value to rotate.
- n  input  SHW  rotate amount, unsigned, 0..WIDTH-1.
- out_valid  output  1  high for exactly the cycle(s) following an accepted input.
- rx  output  WIDTH  rotated result, registered.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high.
- Function: rx = (rin >> n) | (rin << (WIDTH - n)), evaluated modulo WIDTH.
  - n = 0 passes rin unchanged; there is no shift-by-WIDTH case.
- Combinational core: log2 barrel rotator with SHW stages. Stage k rotates by 2^k when n[k] = 1, otherwise passes through. No arithmetic or sign handling; purely a bit permutation.
- Latency: 1 cycle. Inputs sampled at rising edge T with in_valid = 1 appear on rx, with out_valid = 1, after edge T.
- in_valid = 0 at an edge:
  - out_valid goes to 0.
  - rx holds its previous value; it is not cleared.
- Back-to-back: a new input may be accepted every cycle. Throughput is 1 per clock; there is no backpressure and no ready signal.
- Reset:
  - When reset = 1 at a rising edge, rx <= 0 and out_valid <= 0, regardless of in_valid.
  - An input presented in the same cycle as reset is dropped.
  - Reset deasserting mid-stream: the first valid input after release is processed normally.
- No state machine beyond the output register and the valid flop.
- All outputs are driven from flops; no combinational path from inputs to outputs.
- X on n or rin while in_valid = 0 must not propagate to rx.

Decomposition:
- Shared ALU package holds the constants WORD_W = 32 and SHAMT_W = 5, and the typedefs word_t (logic [WORD_W-1:0]) and shamt_t (logic [SHAMT_W-1:0]).
- One natural sub-module: ror_barrel_comb, the purely combinational SHW-stage rotator (rin, n -> rotated).
- The top level adds the valid flop and the result register around ror_barrel_comb.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid = 1, rin = 0xFFFFFFFF -> rx = 0x00000000, out_valid = 0 throughout; first valid input after release is processed normally.
- Mixed pattern: rin = 0xE0FFC003, n = 12 -> rx = 0x003E0FFC one cycle later, out_valid = 1.
- Low-bit wrap: rin = 924385 (0x000E1AE1), n = 5 -> rx = 0x080070D7. Then rin = 3, n = 1 -> rx = 0x80000001.
- MSB wrap and identity: rin = 0x80000000, n = 25 -> rx = 0x00000040. Then rin = 15, n = 0 -> rx = 0x0000000F.
- Streaming and hold:
  - Present the four previous vectors on consecutive cycles -> four consecutive correct results with out_valid = 1 each cycle.
  - Then drop in_valid -> out_valid = 0, rx holds 0x0000000F.
- Exhaustive/random sweep: for a walking-one rin and every n in 0..31, check rx against the reference formula. Then run 10k random (rin, n) pairs with random in_valid gaps and compare each result against the formula.
